// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Brief    : Shared types and constants for the pipeline control blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Default register index width of the 64-bit core (32 architectural regs).
  localparam int REG_W_DEF = 5;

  // XZR reads as zero and discards writes, so it can never carry a hazard.
  localparam logic [REG_W_DEF-1:0] ZERO_REG_IDX = 5'd31;

  typedef logic [REG_W_DEF-1:0] reg_idx_t;

  // Hazard scheduler states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush scheduler for the 5-stage pipeline. Sequences the
//             PC, IF/ID, ID/EX and EX/MEM enables around load-use hazards,
//             data-memory wait states and taken branches resolved in ID.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int ZERO_REG     = int'(ZERO_REG_IDX),
  parameter int CNT_W        = 32,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Wide enough for the largest supported wait limit (255).
  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
  localparam logic [REG_W-1:0]  XZR      = REG_W'(ZERO_REG);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic lu;
  logic mw;

  // A load in EX whose result is needed by ID cannot be forwarded in time.
  assign lu = ex_mem_read && ex_reg_write && (ex_rd != XZR) &&
              ((id_uses_rn && (id_rn == ex_rd)) ||
               (id_uses_rm && (id_rm == ex_rd)));

  assign mw = mem_req && !mem_ready;

  // Mealy output and next-state decode; memory wait beats load-use beats branch.
  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_hold    = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      RUN, LOAD_STALL: begin
        if (mw) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          exmem_hold = 1'b1;
          wait_cnt_d = WAIT_W'(1);
          state_d    = MEM_WAIT;
        end else if (lu && (state_q == RUN)) begin
          // In LOAD_STALL the bubble already sits in EX, so lu is stale.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = LOAD_STALL;
        end else begin
          ifid_flush = br_taken;
          state_d    = RUN;
        end
      end

      MEM_WAIT: begin
        if (mem_ready || (wait_cnt_q == WAIT_MAX)) begin
          // Release cycle: memory is treated as done, lu and branch apply.
          if (!mem_ready) begin
            mem_timeout_d = 1'b1;
          end
          wait_cnt_d = '0;
          if (lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LOAD_STALL;
          end else begin
            ifid_flush = br_taken;
            state_d    = RUN;
          end
        end else begin
          // Full freeze; a branch in ID is held and re-resolves on release.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          exmem_hold = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (reset) begin
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      exmem_hold    = 1'b0;
      state_d       = RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b0;
    end
  end

  // Scheduler state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_en),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             with literal expectations, then randomized traffic against a
//             cycle-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int MAXW   = 15;
  localparam int N_RAND = 4000;

  logic        clk;
  logic        reset;
  reg_idx_t    id_rn, id_rm, ex_rd;
  logic        id_uses_rn, id_uses_rm, ex_mem_read, ex_reg_write;
  logic        br_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, exmem_hold, mem_timeout;
  logic [31:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(
    .REG_W(5), .ZERO_REG(31), .CNT_W(32), .MAX_MEM_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare (every cycle) ----------------
  // The model thinks in terms of "how many freeze cycles in a row so far" and
  // "did last cycle insert a bubble", rather than named states.
  bit started = 1'b0;
  int m_freeze_run = 0;
  bit m_prev_bubble = 1'b0;
  bit m_timeout = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  bit e_pc, e_ifen, e_flush, e_bub, e_hold, e_lu, e_mw, frz, lu_ok, to_now;

  always @(negedge clk) begin
    if (reset) started = 1'b1;
    if (started) begin
      e_pc = 1'b1; e_ifen = 1'b1; e_flush = 1'b0; e_bub = 1'b0; e_hold = 1'b0;
      frz = 1'b0; to_now = 1'b0; lu_ok = !m_prev_bubble;
      e_mw = mem_req && !mem_ready;
      e_lu = ex_mem_read && ex_reg_write && (ex_rd != 5'd31) &&
             ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
      if (!reset) begin
        if (m_freeze_run > 0) begin
          lu_ok = 1'b1;
          if (!mem_ready) begin
            if (m_freeze_run == MAXW) to_now = 1'b1;
            else frz = 1'b1;
          end
        end else if (e_mw) begin
          frz = 1'b1;
        end
        if (frz) begin
          e_pc = 1'b0; e_ifen = 1'b0; e_hold = 1'b1;
        end else if (e_lu && lu_ok) begin
          e_pc = 1'b0; e_ifen = 1'b0; e_bub = 1'b1;
        end else if (br_taken) begin
          e_flush = 1'b1;
        end
      end

      check("pc_en",       32'(pc_en),       32'(e_pc));
      check("ifid_en",     32'(ifid_en),     32'(e_ifen));
      check("ifid_flush",  32'(ifid_flush),  32'(e_flush));
      check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
      check("exmem_hold",  32'(exmem_hold),  32'(e_hold));
      check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
      check("stall_count", stall_count,      32'(m_stall));
      check("flush_count", flush_count,      32'(m_flush));
      check("flush_vs_en", 32'(ifid_flush && !ifid_en), 32'd0);

      if (reset) begin
        m_freeze_run = 0; m_prev_bubble = 1'b0; m_timeout = 1'b0;
        m_stall = 0; m_flush = 0;
      end else begin
        m_freeze_run  = frz ? m_freeze_run + 1 : 0;
        m_prev_bubble = e_bub;
        if (to_now) m_timeout = 1'b1;
        if (!e_pc) m_stall++;
        if (e_flush) m_flush++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic set_load_use(input reg_idx_t r);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = r;
    id_rn = r; id_uses_rn = 1'b1;
  endtask

  function automatic reg_idx_t pick_reg();
    reg_idx_t t;
    case ($urandom_range(0, 3))
      0: t = 5'd1;
      1: t = 5'd2;
      2: t = 5'd31;
      default: t = reg_idx_t'($urandom_range(0, 31));
    endcase
    return t;
  endfunction

  int hang = 0;

  initial begin
    reset = 1'b1;
    clear_inputs();
    step(); step();
    reset = 1'b0;

    // Load-use on X1: one bubble cycle, then defaults.
    do_reset();
    step(); set_load_use(5'd1); #2;
    check("lu_pc_en", 32'(pc_en), 32'd0);
    check("lu_ifid_en", 32'(ifid_en), 32'd0);
    check("lu_bubble", 32'(idex_bubble), 32'd1);
    step(); #2;
    check("lu_after_pc_en", 32'(pc_en), 32'd1);
    check("lu_after_bubble", 32'(idex_bubble), 32'd0);
    step(); clear_inputs(); #2;
    check("lu_stall_count", stall_count, 32'd1);

    // Load to XZR never stalls.
    do_reset();
    step(); set_load_use(5'd31); #2;
    check("xzr_pc_en", 32'(pc_en), 32'd1);
    check("xzr_bubble", 32'(idex_bubble), 32'd0);
    step(); clear_inputs(); #2;
    check("xzr_stall_count", stall_count, 32'd0);

    // Taken branch in RUN flushes the same cycle.
    do_reset();
    step(); br_taken = 1'b1; #2;
    check("br_flush", 32'(ifid_flush), 32'd1);
    check("br_pc_en", 32'(pc_en), 32'd1);
    step(); br_taken = 1'b0; #2;
    check("br_flush_count", flush_count, 32'd1);

    // Three wait cycles then ready.
    do_reset();
    step(); mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #2;
      check("mw_hold", 32'(exmem_hold), 32'd1);
      check("mw_pc_en", 32'(pc_en), 32'd0);
    end
    step(); mem_ready = 1'b1; #2;
    check("mw_release_hold", 32'(exmem_hold), 32'd0);
    check("mw_release_pc_en", 32'(pc_en), 32'd1);
    step(); mem_req = 1'b0; mem_ready = 1'b0; #2;
    check("mw_stall_count", stall_count, 32'd3);

    // Memory never ready: 15 freezes, forced release, sticky timeout.
    do_reset();
    step(); mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      if (i > 0) step();
      #2;
      check("to_hold", 32'(exmem_hold), 32'd1);
    end
    step(); #2;
    check("to_release_hold", 32'(exmem_hold), 32'd0);
    check("to_release_pc_en", 32'(pc_en), 32'd1);
    check("to_flag_not_yet", 32'(mem_timeout), 32'd0);
    step(); mem_req = 1'b0; #2;
    check("to_flag", 32'(mem_timeout), 32'd1);
    check("to_stall_count", stall_count, 32'(MAXW));
    step(); #2;
    check("to_flag_sticky", 32'(mem_timeout), 32'd1);

    // lu + mw + branch together, then reset while frozen.
    do_reset();
    step(); set_load_use(5'd2); mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1; #2;
    check("mix_hold", 32'(exmem_hold), 32'd1);
    check("mix_bubble", 32'(idex_bubble), 32'd0);
    check("mix_flush", 32'(ifid_flush), 32'd0);
    step(); #2;
    check("mix_frozen_flush", 32'(ifid_flush), 32'd0);
    check("mix_frozen_pc_en", 32'(pc_en), 32'd0);
    step(); reset = 1'b1; #2;
    check("mix_rst_pc_en", 32'(pc_en), 32'd1);
    check("mix_rst_hold", 32'(exmem_hold), 32'd0);
    step(); reset = 1'b0; clear_inputs(); #2;
    check("mix_post_hold", 32'(exmem_hold), 32'd0);
    check("mix_post_stall", stall_count, 32'd0);
    check("mix_post_flush", flush_count, 32'd0);
    check("mix_post_timeout", 32'(mem_timeout), 32'd0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < N_RAND; c++) begin
      step();
      reset        = ($urandom_range(0, 249) == 0);
      ex_rd        = pick_reg();
      id_rn        = pick_reg();
      id_rm        = pick_reg();
      id_uses_rn   = $urandom_range(0, 1) == 1;
      id_uses_rm   = $urandom_range(0, 1) == 1;
      ex_mem_read  = $urandom_range(0, 2) == 0;
      ex_reg_write = $urandom_range(0, 3) != 0;
      br_taken     = $urandom_range(0, 4) == 0;
      if (hang == 0 && $urandom_range(0, 149) == 0) hang = 20;
      if (hang > 0) begin
        hang--;
        mem_req = 1'b1; mem_ready = 1'b0;
      end else begin
        mem_req   = $urandom_range(0, 2) == 0;
        mem_ready = $urandom_range(0, 4) < 2;
      end
    end
    step();
    clear_inputs();
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
